load_store_unit: RTL and testbench

Initiator side of the data-memory interface: accepts load/store requests from the MEM stage, converts byte addresses to word indices, and issues accesses to `data_mem`. Sub-word stores (sb/sh) are done as read-modify-write on the word-wide memory. Loads (lb/lbu/lh/lhu/lw) are returned aligned and sign- or zero-extended. The MEM stage stalls on `req_ready`.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/load_store_unit_if.sv | 26 ++
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the address alignment check.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } lsu_state_e;

  // Size code 2'b11 falls into the default branch and is checked as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the MEM stage and the load/store unit.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_range;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_range
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign, resp_range
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extracts and extends load lanes from a memory
// word, and merges sub-word store data into a memory word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]         byte_sh;
  logic [4:0]         half_sh;
  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;

  // Big-endian puts lane 0 in the most significant position, so the shift counts down.
  always_comb begin
    if (BIG_ENDIAN) begin
      byte_sh = {~offset, 3'b000};
      half_sh = {~offset[1], 4'b0000};
    end else begin
      byte_sh = {offset, 3'b000};
      half_sh = {offset[1], 4'b0000};
    end
  end

  assign byte_lane = 8'(word >> byte_sh);
  assign half_lane = 16'(word >> half_sh);

  always_comb begin
    case (size)
      SZ_BYTE: begin
        if (is_unsigned) load_data = {24'b0, byte_lane};
        else             load_data = 32'(byte_lane);
      end
      SZ_HALF: begin
        if (is_unsigned) load_data = {16'b0, half_lane};
        else             load_data = 32'(half_lane);
      end
      default: load_data = word;
    endcase
  end

  always_comb begin
    case (size)
      SZ_BYTE: merged = (word & ~(32'h0000_00FF << byte_sh)) | ({24'b0, wdata[7:0]} << byte_sh);
      SZ_HALF: merged = (word & ~(32'h0000_FFFF << half_sh)) | ({16'b0, wdata[15:0]} << half_sh);
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding FSM that turns byte-addressed requests
// into word accesses, with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS  = 256,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus,
  output logic               mem_wr_en,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  lsu_state_e  state;
  lsu_state_e  state_nxt;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        misalign_q;
  logic        range_q;

  logic        req_misalign;
  logic        req_range;
  logic        accept;
  logic        subword_store;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_misalign  = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign req_range     = {2'b00, bus.req_addr[31:2]} >= MEM_WORDS_W;
  assign accept        = (state == IDLE) && bus.req_valid;
  assign subword_store = we_q && (size_q != SZ_WORD);

  lsu_lane_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (addr_q[1:0]),
    .word        (mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.req_valid) state_nxt = (req_misalign || req_range) ? RESP : ACCESS;
      ACCESS:   state_nxt = subword_store ? MERGE_WR : RESP;
      MERGE_WR: state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Response state: cleared on acceptance so stores and errors return zero data
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
    end else if (accept) begin
      rdata_q    <= '0;
      misalign_q <= req_misalign;
      range_q    <= req_range;
    end else if (state == ACCESS && !we_q) begin
      rdata_q    <= load_data;
    end
  end

  // Request payload and merged word; qualified by the FSM, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= (bus.req_size == 2'b11) ? SZ_WORD : bus.req_size;
      uns_q   <= bus.req_unsigned;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
    if (state == ACCESS) merged_q <= merged;
  end

  // Output logic
  always_comb begin
    bus.req_ready     = (state == IDLE);
    bus.resp_valid    = (state == RESP);
    bus.resp_rdata    = rdata_q;
    bus.resp_misalign = (state == RESP) && misalign_q;
    bus.resp_range    = (state == RESP) && range_q;
    mem_wr_en         = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    case (state)
      ACCESS: begin
        mem_addr = {2'b00, addr_q[31:2]};
        if (we_q && !subword_store) begin
          mem_wr_en = ~rst;
          mem_wdata = wdata_q;
        end
      end
      MERGE_WR: begin
        mem_addr  = {2'b00, addr_q[31:2]};
        mem_wr_en = ~rst;
        mem_wdata = merged_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: big- and little-endian instances, each
// attached to a small behavioural word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        init;
  logic        sel_le;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  load_store_unit_if bus_be();
  load_store_unit_if bus_le();

  assign bus_be.req_valid    = req_valid & ~sel_le;
  assign bus_be.req_we       = req_we;
  assign bus_be.req_size     = req_size;
  assign bus_be.req_unsigned = req_unsigned;
  assign bus_be.req_addr     = req_addr;
  assign bus_be.req_wdata    = req_wdata;
  assign bus_le.req_valid    = req_valid & sel_le;
  assign bus_le.req_we       = req_we;
  assign bus_le.req_size     = req_size;
  assign bus_le.req_unsigned = req_unsigned;
  assign bus_le.req_addr     = req_addr;
  assign bus_le.req_wdata    = req_wdata;

  logic        wr_be, wr_le;
  logic [31:0] addr_be, addr_le, wd_be, wd_le, rd_be, rd_le;
  logic [31:0] mem_be [256];
  logic [31:0] mem_le [256];

  load_store_unit #(.MEM_WORDS(256), .BIG_ENDIAN(1'b1)) dut_be (
    .clk (clk), .rst (rst), .bus (bus_be.slave),
    .mem_wr_en (wr_be), .mem_addr (addr_be), .mem_wdata (wd_be), .mem_rdata (rd_be)
  );

  load_store_unit #(.MEM_WORDS(256), .BIG_ENDIAN(1'b0)) dut_le (
    .clk (clk), .rst (rst), .bus (bus_le.slave),
    .mem_wr_en (wr_le), .mem_addr (addr_le), .mem_wdata (wd_le), .mem_rdata (rd_le)
  );

  always @(posedge clk) begin
    if (init) begin
      mem_be[4] <= 32'h1122_3344;
      mem_be[5] <= 32'h8899_AABB;
      mem_le[4] <= 32'h1122_3344;
      mem_le[5] <= 32'h8899_AABB;
    end else begin
      if (wr_be && addr_be < 32'd256) mem_be[addr_be[7:0]] <= wd_be;
      if (wr_le && addr_le < 32'd256) mem_le[addr_le[7:0]] <= wd_le;
    end
  end
  assign rd_be = mem_be[addr_be[7:0]];
  assign rd_le = mem_le[addr_le[7:0]];

  int wr_cnt = 0;
  always @(posedge clk) if (wr_be || wr_le) wr_cnt <= wr_cnt + 1;

  logic        o_ready, o_valid, o_mis, o_rng;
  logic [31:0] o_rdata;
  assign o_ready = sel_le ? bus_le.req_ready     : bus_be.req_ready;
  assign o_valid = sel_le ? bus_le.resp_valid    : bus_be.resp_valid;
  assign o_mis   = sel_le ? bus_le.resp_misalign : bus_be.resp_misalign;
  assign o_rng   = sel_le ? bus_le.resp_range    : bus_be.resp_range;
  assign o_rdata = sel_le ? bus_le.resp_rdata    : bus_be.resp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issues one request from a negedge and returns at the negedge of the response cycle.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic mis, output logic rng, output int busy);
    int w;
    w = 0;
    while (!o_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = -1; rd = 32'hDEAD_DEAD; mis = 1'b0; rng = 1'b0; busy = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (!o_ready) busy++;
      if (o_valid) begin
        lat = n; rd = o_rdata; mis = o_mis; rng = o_rng;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic preload();
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  logic [1:0]  p_sz   [5];
  logic        p_uns  [5];
  logic [31:0] p_addr [5];
  logic [31:0] p_exp  [5];

  int          lat, busy, w0;
  logic [31:0] rd;
  logic        mis, rng;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    p_sz[0] = SZ_WORD; p_uns[0] = 1'b0; p_addr[0] = 32'h10; p_exp[0] = 32'h1122_3344;
    p_sz[1] = 2'b11;   p_uns[1] = 1'b0; p_addr[1] = 32'h14; p_exp[1] = 32'h8899_AABB;
    p_sz[2] = SZ_BYTE; p_uns[2] = 1'b0; p_addr[2] = 32'h13; p_exp[2] = 32'h0000_0044;
    p_sz[3] = SZ_HALF; p_uns[3] = 1'b0; p_addr[3] = 32'h14; p_exp[3] = 32'hFFFF_8899;
    p_sz[4] = SZ_BYTE; p_uns[4] = 1'b1; p_addr[4] = 32'h15; p_exp[4] = 32'h0000_0099;

    rst = 1'b1; init = 1'b1; sel_le = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready",    o_ready, 1);
    check_eq("rst_valid",    o_valid, 0);
    check_eq("rst_rdata",    o_rdata, 0);
    check_eq("rst_misalign", o_mis,   0);
    check_eq("rst_range",    o_rng,   0);
    check_eq("rst_wr_en",    wr_be,   0);
    check_eq("rst_mem_addr", addr_be, 0);
    check_eq("rst_mem_wd",   wd_be,   0);
    rst = 1'b0; init = 1'b0;
    @(negedge clk);

    do_req(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, lat, rd, mis, rng, busy);
    check_eq("lb_11_data", rd, 32'h0000_0022);
    check_eq("lb_11_lat",  lat, 2);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h14, 32'h0, lat, rd, mis, rng, busy);
    check_eq("lb_14_data", rd, 32'hFFFF_FF88);
    check_eq("lb_14_lat",  lat, 2);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h14, 32'h0, lat, rd, mis, rng, busy);
    check_eq("lbu_14_data", rd, 32'h0000_0088);
    check_eq("lbu_14_lat",  lat, 2);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, lat, rd, mis, rng, busy);
    check_eq("lhu_16_data", rd, 32'h0000_AABB);
    check_eq("lhu_16_lat",  lat, 2);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, lat, rd, mis, rng, busy);
    check_eq("lh_16_data", rd, 32'hFFFF_AABB);

    w0 = wr_cnt;
    do_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hCAFE_BEEF, lat, rd, mis, rng, busy);
    check_eq("sh_be_lat",   lat, 3);
    check_eq("sh_be_rdata", rd, 32'h0);
    check_eq("sh_be_word",  mem_be[4], 32'h1122_BEEF);
    check_eq("sh_be_wrcnt", wr_cnt - w0, 1);

    sel_le = 1'b1;
    w0 = wr_cnt;
    do_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hCAFE_BEEF, lat, rd, mis, rng, busy);
    check_eq("sh_le_lat",   lat, 3);
    check_eq("sh_le_word",  mem_le[4], 32'hBEEF_3344);
    check_eq("sh_le_wrcnt", wr_cnt - w0, 1);
    @(negedge clk);
    sel_le = 1'b0;

    do_req(1'b1, SZ_WORD, 1'b0, 32'h14, 32'hDEAD_BEEF, lat, rd, mis, rng, busy);
    check_eq("sw_lat",   lat, 2);
    check_eq("sw_busy",  busy, 2);
    check_eq("sw_rdata", rd, 32'h0);
    check_eq("sw_word",  mem_be[5], 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("sw_ready_back", o_ready, 1);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, lat, rd, mis, rng, busy);
    check_eq("lw_data", rd, 32'hDEAD_BEEF);
    check_eq("lw_lat",  lat, 2);
    check_eq("lw_busy", busy, 2);
    @(negedge clk);
    check_eq("lw_ready_back", o_ready, 1);

    w0 = wr_cnt;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, lat, rd, mis, rng, busy);
    check_eq("lw_13_misalign", mis, 1);
    check_eq("lw_13_range",    rng, 0);
    check_eq("lw_13_lat",      lat, 1);
    check_eq("lw_13_rdata",    rd, 32'h0);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h400, 32'h55, lat, rd, mis, rng, busy);
    check_eq("sb_400_range",    rng, 1);
    check_eq("sb_400_misalign", mis, 0);
    check_eq("sb_400_lat",      lat, 1);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h401, 32'h0, lat, rd, mis, rng, busy);
    check_eq("lh_401_both", {30'b0, mis, rng}, 32'h3);
    check_eq("err_wrcnt",   wr_cnt - w0, 0);
    check_eq("err_word4",   mem_be[4], 32'h1122_BEEF);
    @(negedge clk);
    check_eq("idle_flags",  {30'b0, o_mis, o_rng}, 32'h0);

    preload();
    w0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("mrg_wr_en", wr_be, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstmid_ready", o_ready, 1);
    check_eq("rstmid_valid", o_valid, 0);
    check_eq("rstmid_word4", mem_be[4], 32'h1122_3344);
    check_eq("rstmid_wrcnt", wr_cnt - w0, 0);
    @(negedge clk);
    check_eq("rstmid_valid2", o_valid, 0);

    preload();
    begin
      int k, rcv, last;
      logic acc;
      k = 0; rcv = 0; last = 0;
      req_we = 1'b0; req_wdata = '0;
      req_size = p_sz[0]; req_unsigned = p_uns[0]; req_addr = p_addr[0];
      req_valid = 1'b1;
      for (int c = 0; c < 24; c++) begin
        if (o_valid) begin
          if (rcv < 5) check_eq($sformatf("pipe_rd%0d", rcv), o_rdata, p_exp[rcv]);
          rcv++;
        end
        acc = o_ready && req_valid;
        @(posedge clk);
        #1;
        if (acc) begin
          if (k > 0) check_eq($sformatf("pipe_gap%0d", k), c - last, 3);
          last = c;
          k++;
          if (k < 5) begin
            req_size = p_sz[k]; req_unsigned = p_uns[k]; req_addr = p_addr[k];
          end else begin
            req_valid = 1'b0;
          end
        end
        @(negedge clk);
      end
      check_eq("pipe_count", rcv, 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
